// File: rtl/div_seq_pkg.sv
// Shared types and sizing helpers for the multi-cycle divider sequencer.
package div_seq_pkg;

    localparam int DIV_DATA_W = 32;

    typedef enum logic [1:0] {
        DIV_FREE   = 2'b00,
        DIV_BYZERO = 2'b01,
        DIV_ON     = 2'b10,
        DIV_END    = 2'b11
    } div_state_e;

    // Counter must be able to hold DATA_W itself, not just DATA_W-1.
    function automatic int div_cnt_w(input int data_w);
        return $clog2(data_w) + 1;
    endfunction

endpackage

// File: rtl/div_seq_if.sv
// EX-stage <-> divider handshake: operands and start/annul in, result/ready/stall out.
interface div_seq_if
    import div_seq_pkg::*;
#(
    parameter int DATA_W = DIV_DATA_W
) ();

    logic                signed_div_i;
    logic [DATA_W-1:0]   opdata1_i;
    logic [DATA_W-1:0]   opdata2_i;
    logic                start_i;
    logic                annul_i;
    logic [2*DATA_W-1:0] result_o;
    logic                ready_o;
    logic                stallreq_o;

    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o, stallreq_o
    );

    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o, stallreq_o
    );

endinterface

// File: rtl/div_seq_step.sv
// One radix-2 restoring iteration: shift a dividend bit into the partial remainder, trial-subtract.
module div_seq_step #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] rem,
    input  logic              dividend_bit,
    input  logic [DATA_W-1:0] divisor,
    output logic [DATA_W-1:0] next_rem,
    output logic              quot_bit
);

    logic [DATA_W:0] shifted;
    logic [DATA_W:0] diff;

    // rem < divisor always holds, so diff's top bit is a clean borrow flag.
    assign shifted  = {rem, dividend_bit};
    assign diff     = shifted - {1'b0, divisor};
    assign quot_bit = ~diff[DATA_W];
    assign next_rem = quot_bit ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];

endmodule

// File: rtl/div_seq.sv
// DIV/DIVU sequencer: load magnitudes, DATA_W shift-subtract steps, sign fix-up, hold result.
module div_seq
    import div_seq_pkg::*;
#(
    parameter int DATA_W = DIV_DATA_W
) (
    input  logic      clk,
    input  logic      Rst_n,
    div_seq_if.slave  bus
);

    localparam int                CNT_W    = div_cnt_w(DATA_W);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [DATA_W-1:0] ONE      = DATA_W'(1);

    div_state_e          state;
    logic [CNT_W-1:0]    cnt;
    logic [2*DATA_W-1:0] work;
    logic [DATA_W-1:0]   divisor;
    logic                neg_quot;
    logic                neg_rem;
    logic [2*DATA_W-1:0] result;
    logic                ready;
    logic [DATA_W-1:0]   step_rem;
    logic                step_qbit;
    logic [DATA_W-1:0]   cur_rem;
    logic [DATA_W-1:0]   cur_quot;

    function automatic logic [DATA_W-1:0] neg2c(input logic [DATA_W-1:0] v);
        return ~v + ONE;
    endfunction

    // Most negative value maps onto itself, which is already its correct unsigned magnitude.
    function automatic logic [DATA_W-1:0] magnitude(input logic is_signed,
                                                    input logic [DATA_W-1:0] v);
        return (is_signed && v[DATA_W-1]) ? neg2c(v) : v;
    endfunction

    assign cur_rem  = work[2*DATA_W-1:DATA_W];
    assign cur_quot = work[DATA_W-1:0];

    div_seq_step #(.DATA_W(DATA_W)) u_step (
        .rem          (cur_rem),
        .dividend_bit (work[DATA_W-1]),
        .divisor      (divisor),
        .next_rem     (step_rem),
        .quot_bit     (step_qbit)
    );

    assign bus.result_o   = result;
    assign bus.ready_o    = ready;
    assign bus.stallreq_o = bus.start_i & ~ready;

    always_ff @(posedge clk or posedge Rst_n) begin
        if (Rst_n) begin
            state    <= DIV_FREE;
            cnt      <= '0;
            work     <= '0;
            divisor  <= '0;
            neg_quot <= 1'b0;
            neg_rem  <= 1'b0;
            result   <= '0;
            ready    <= 1'b0;
        end else begin
            case (state)
                DIV_FREE: begin
                    if (bus.start_i && !bus.annul_i) begin
                        if (bus.opdata2_i == '0) begin
                            state <= DIV_BYZERO;
                        end else begin
                            state    <= DIV_ON;
                            cnt      <= '0;
                            work     <= {{DATA_W{1'b0}},
                                         magnitude(bus.signed_div_i, bus.opdata1_i)};
                            divisor  <= magnitude(bus.signed_div_i, bus.opdata2_i);
                            neg_rem  <= bus.signed_div_i & bus.opdata1_i[DATA_W-1];
                            neg_quot <= bus.signed_div_i &
                                        (bus.opdata1_i[DATA_W-1] ^ bus.opdata2_i[DATA_W-1]);
                        end
                    end
                end
                DIV_BYZERO: begin
                    if (bus.annul_i) begin
                        state <= DIV_FREE;
                    end else begin
                        state  <= DIV_END;
                        result <= '0;
                        ready  <= 1'b1;
                    end
                end
                DIV_ON: begin
                    if (bus.annul_i) begin
                        state <= DIV_FREE;
                        cnt   <= '0;
                    end else if (cnt != CNT_LAST) begin
                        // Quotient bits shift in at the bottom as dividend bits leave the top.
                        work <= {step_rem, work[DATA_W-2:0], step_qbit};
                        cnt  <= cnt + CNT_ONE;
                    end else begin
                        result <= {neg_rem  ? neg2c(cur_rem)  : cur_rem,
                                   neg_quot ? neg2c(cur_quot) : cur_quot};
                        ready  <= 1'b1;
                        state  <= DIV_END;
                    end
                end
                DIV_END: begin
                    if (!bus.start_i) begin
                        state  <= DIV_FREE;
                        ready  <= 1'b0;
                        result <= '0;
                    end
                end
                default: state <= DIV_FREE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq.sv
// Scoreboard bench for div_seq: latency, results, stall, annul and async reset behaviour.
module tb_div_seq;
    import div_seq_pkg::*;

    localparam int W = 32;

    logic clk = 1'b0;
    logic Rst_n = 1'b1;
    int   errors = 0;
    int   checks = 0;
    logic [2*W-1:0] exp_q[$];

    always #5 clk = ~clk;

    div_seq_if #(.DATA_W(W)) bus ();

    div_seq #(.DATA_W(W)) dut (
        .clk   (clk),
        .Rst_n (Rst_n),
        .bus   (bus)
    );

    function automatic logic [2*W-1:0] model(input logic s, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        longint na, nb, q, r;
        if (b == '0) return '0;
        if (s) begin
            na = longint'($signed(a));
            nb = longint'($signed(b));
        end else begin
            na = longint'({32'h0, a});
            nb = longint'({32'h0, b});
        end
        q = na / nb;
        r = na % nb;
        return {r[W-1:0], q[W-1:0]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_div(input string name, input logic s, input logic [W-1:0] a,
                           input logic [W-1:0] b);
        int edges;
        int lat;
        logic bad_wait;
        logic [2*W-1:0] exp;
        lat = (b == '0) ? 2 : 34;
        exp_q.push_back(model(s, a, b));
        bus.signed_div_i = s;
        bus.opdata1_i    = a;
        bus.opdata2_i    = b;
        bus.annul_i      = 1'b0;
        bus.start_i      = 1'b1;
        edges    = 0;
        bad_wait = 1'b0;
        while (edges < 60) begin
            step();
            edges++;
            if (edges == 1) begin
                bus.opdata1_i    = $urandom;
                bus.opdata2_i    = $urandom;
                bus.signed_div_i = ~s;
            end
            if (bus.ready_o === 1'b1) break;
            if (bus.stallreq_o !== 1'b1 || bus.result_o !== '0) bad_wait = 1'b1;
        end
        exp = exp_q.pop_front();
        checks++;
        if (edges !== lat)
            $display("FAIL %s latency: got %0d edges, want %0d", name, edges, lat);
        if (edges !== lat) errors++;
        checks++;
        if (bad_wait) begin
            errors++;
            $display("FAIL %s wait: stall/result wrong before ready, want stall=1 result=0", name);
        end
        checks++;
        if (bus.result_o !== exp) begin
            errors++;
            $display("FAIL %s result: got %h, want %h", name, bus.result_o, exp);
        end
        checks++;
        if (bus.stallreq_o !== 1'b0) begin
            errors++;
            $display("FAIL %s stall_at_ready: got %b, want 0", name, bus.stallreq_o);
        end
        bus.annul_i = 1'b1;
        step();
        checks++;
        if (bus.ready_o !== 1'b1 || bus.result_o !== exp) begin
            errors++;
            $display("FAIL %s hold_in_end: got ready=%b result=%h, want 1 %h",
                     name, bus.ready_o, bus.result_o, exp);
        end
        bus.annul_i = 1'b0;
        bus.start_i = 1'b0;
        step();
        checks++;
        if (bus.ready_o !== 1'b0 || bus.result_o !== '0) begin
            errors++;
            $display("FAIL %s release: got ready=%b result=%h, want 0 0",
                     name, bus.ready_o, bus.result_o);
        end
        step();
    endtask

    task automatic test_reset();
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = '0;
        bus.opdata2_i    = '0;
        bus.start_i      = 1'b0;
        bus.annul_i      = 1'b0;
        Rst_n            = 1'b1;
        #1;
        checks++;
        if (bus.ready_o !== 1'b0 || bus.result_o !== '0 || bus.stallreq_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got ready=%b result=%h stall=%b, want 0 0 0",
                     bus.ready_o, bus.result_o, bus.stallreq_o);
        end
        step();
        step();
        Rst_n = 1'b0;
        step();
    endtask

    task automatic test_unsigned();
        run_div("divu_100_7", 1'b0, 32'd100, 32'd7);
        run_div("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1);
    endtask

    task automatic test_signed();
        run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'h2);
        run_div("div_7_m2", 1'b1, 32'h7, 32'hFFFF_FFFE);
        run_div("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    endtask

    task automatic test_by_zero();
        run_div("divu_by_zero", 1'b0, 32'd1234, 32'd0);
        run_div("div_by_zero", 1'b1, 32'hFFFF_FF00, 32'd0);
    endtask

    task automatic test_annul();
        int seen;
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = 32'd1000;
        bus.opdata2_i    = 32'd3;
        bus.annul_i      = 1'b0;
        bus.start_i      = 1'b1;
        repeat (11) step();
        bus.annul_i = 1'b1;
        step();
        bus.start_i = 1'b0;
        bus.annul_i = 1'b0;
        seen = 0;
        repeat (40) begin
            step();
            if (bus.ready_o !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL annul_on: ready seen %0d cycles, want 0", seen);
        end
        run_div("after_annul", 1'b0, 32'd1000, 32'd3);
        bus.opdata1_i = 32'd100;
        bus.opdata2_i = 32'd7;
        bus.start_i   = 1'b1;
        bus.annul_i   = 1'b1;
        seen = 0;
        repeat (5) begin
            step();
            if (bus.ready_o !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL annul_free: ready seen %0d cycles, want 0", seen);
        end
        run_div("start_after_annul_free", 1'b1, 32'd100, 32'd7);
    endtask

    task automatic test_async_reset();
        int edges;
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = 32'd100;
        bus.opdata2_i    = 32'd7;
        bus.annul_i      = 1'b0;
        bus.start_i      = 1'b1;
        repeat (15) step();
        #2;
        Rst_n = 1'b1;
        #1;
        checks++;
        if (bus.ready_o !== 1'b0 || bus.result_o !== '0) begin
            errors++;
            $display("FAIL reset_mid_on: got ready=%b result=%h, want 0 0",
                     bus.ready_o, bus.result_o);
        end
        bus.start_i = 1'b0;
        step();
        Rst_n = 1'b0;
        step();
        bus.opdata1_i = 32'd500;
        bus.opdata2_i = 32'd9;
        bus.start_i   = 1'b1;
        edges = 0;
        while (edges < 60 && bus.ready_o !== 1'b1) begin
            step();
            edges++;
        end
        #2;
        Rst_n = 1'b1;
        #1;
        checks++;
        if (edges != 34 || bus.ready_o !== 1'b0 || bus.result_o !== '0) begin
            errors++;
            $display("FAIL reset_in_end: edges=%0d ready=%b result=%h, want 34 0 0",
                     edges, bus.ready_o, bus.result_o);
        end
        bus.start_i = 1'b0;
        step();
        Rst_n = 1'b0;
        step();
        run_div("after_reset", 1'b0, 32'd100, 32'd7);
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] a;
        logic [W-1:0] b;
        for (int i = 0; i < 6; i++) begin
            a = $urandom;
            b = (i < 3) ? W'($urandom_range(1, 1000)) : W'($urandom | 1);
            run_div("random", i[0], a, b);
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_by_zero();
        test_annul();
        test_async_reset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
